// File: rtl/fm_pkg.sv
// rtl/fm_pkg.sv - shared types, vibrato constants and MULT decode for the FM phase sequencer
package fm_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RUN  = 2'd2
    } fm_state_e;

    // Vibrato range is taken from the F-number MSBs and halved for fine position / shallow depth
    localparam int VIB_RANGE_W       = 3;
    localparam int VIB_FINE_SHIFT    = 1;
    localparam int VIB_SHALLOW_SHIFT = 1;

    function automatic logic [4:0] fm_mult_factor(input logic [3:0] mult);
        logic [4:0] factor;
        case (mult)
            4'd0:           factor = 5'd1;
            4'd1:           factor = 5'd2;
            4'd2:           factor = 5'd4;
            4'd3:           factor = 5'd6;
            4'd4:           factor = 5'd8;
            4'd5:           factor = 5'd10;
            4'd6:           factor = 5'd12;
            4'd7:           factor = 5'd14;
            4'd8:           factor = 5'd16;
            4'd9:           factor = 5'd18;
            4'd10, 4'd11:   factor = 5'd20;
            4'd12, 4'd13:   factor = 5'd24;
            default:        factor = 5'd30;
        endcase
        return factor;
    endfunction

endpackage

// File: rtl/fm_phase_inc.sv
// rtl/fm_phase_inc.sv - combinational vibrato, octave and multiplier path producing the phase increment
module fm_phase_inc
    import fm_pkg::*;
#(
    parameter int FNUM_W  = 10,
    parameter int PHASE_W = 19
) (
    input  logic [FNUM_W-1:0]  fnum,
    input  logic [2:0]         block,
    input  logic [3:0]         mult,
    input  logic               vib,
    input  logic               dvb,
    input  logic [2:0]         vib_pos,
    output logic [PHASE_W-1:0] inc
);

    // Wide enough for fnum << 7 times 30 without loss before the final truncation
    localparam int PROD_W = (FNUM_W + 12 > PHASE_W + 1) ? FNUM_W + 12 : PHASE_W + 1;

    logic [VIB_RANGE_W-1:0] range;
    logic [FNUM_W-1:0]      f;
    logic [PROD_W-1:0]      shifted;
    logic [PROD_W-1:0]      prod;

    always_comb begin
        range = fnum[FNUM_W-1 -: VIB_RANGE_W];
        if (!vib || vib_pos[1:0] == 2'b00) begin
            range = '0;
        end else if (vib_pos[0]) begin
            range = range >> VIB_FINE_SHIFT;
        end
        if (!dvb) begin
            range = range >> VIB_SHALLOW_SHIFT;
        end
        f       = vib_pos[2] ? fnum - FNUM_W'(range) : fnum + FNUM_W'(range);
        shifted = (PROD_W'(f) << block) >> 1;
        prod    = shifted * PROD_W'(fm_mult_factor(mult));
        inc     = PHASE_W'(prod >> 1);
    end

endmodule

// File: rtl/fm_phase_seq.sv
// rtl/fm_phase_seq.sv - per-sample operator sweep: parameter fetch, phase accumulate, phase stream out
module fm_phase_seq
    import fm_pkg::*;
#(
    parameter int NUM_OPS = 64,
    parameter int OP_W    = $clog2(NUM_OPS),
    parameter int FNUM_W  = 10,
    parameter int PHASE_W = 19,
    parameter int OUT_W   = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_start,
    input  logic [2:0]        vib_pos,
    output logic              busy,
    output logic              overrun,
    output logic [OP_W-1:0]   param_addr,
    input  logic [2:0]        p_block,
    input  logic [FNUM_W-1:0] p_fnum,
    input  logic [3:0]        p_mult,
    input  logic              p_vib,
    input  logic              p_dvb,
    input  logic              p_restart,
    output logic              phase_valid,
    output logic [OP_W-1:0]   phase_op,
    output logic [OUT_W-1:0]  phase_out
);

    localparam logic [OP_W-1:0] LAST_OP  = OP_W'(NUM_OPS - 1);
    localparam logic [OP_W:0]   INIT_END = (OP_W + 1)'(NUM_OPS);

    fm_state_e           state;
    fm_state_e           state_nxt;
    logic [OP_W:0]       init_idx;
    logic                addr_vld;
    logic                s1_vld;
    logic [OP_W-1:0]     s1_op;
    logic [2:0]          vib_pos_q;
    logic                start_ok;
    logic                init_wr;

    logic [PHASE_W-1:0]  acc_mem [NUM_OPS];
    logic [PHASE_W-1:0]  acc_old;
    logic [PHASE_W-1:0]  acc_new;
    logic [PHASE_W-1:0]  inc;
    logic                wr_en;
    logic [OP_W-1:0]     wr_addr;
    logic [PHASE_W-1:0]  wr_data;

    assign start_ok = (state == IDLE) && sample_start;
    assign init_wr  = (state == INIT) && (init_idx != INIT_END);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (init_idx == INIT_END) state_nxt = IDLE;
            IDLE:    if (sample_start) state_nxt = RUN;
            RUN:     if (s1_vld && s1_op == LAST_OP) state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    // addr_vld marks a request on param_addr; s1 is the cycle its parameters return
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy        <= 1'b0;
            overrun     <= 1'b0;
            init_idx    <= '0;
            param_addr  <= '0;
            addr_vld    <= 1'b0;
            s1_vld      <= 1'b0;
            s1_op       <= '0;
            vib_pos_q   <= '0;
            phase_valid <= 1'b0;
            phase_op    <= '0;
            phase_out   <= '0;
        end else begin
            busy    <= (state_nxt != IDLE);
            overrun <= sample_start && (state != IDLE);
            if (init_wr) begin
                init_idx <= init_idx + (OP_W + 1)'(1);
            end
            s1_vld <= addr_vld;
            s1_op  <= param_addr;
            if (start_ok) begin
                param_addr <= '0;
                addr_vld   <= 1'b1;
                vib_pos_q  <= vib_pos;
            end else if (addr_vld) begin
                addr_vld <= (param_addr != LAST_OP);
                if (param_addr != LAST_OP) begin
                    param_addr <= param_addr + OP_W'(1);
                end
            end
            phase_valid <= s1_vld;
            if (s1_vld) begin
                phase_op  <= s1_op;
                phase_out <= acc_old[PHASE_W-1 -: OUT_W];
            end
        end
    end

    fm_phase_inc #(
        .FNUM_W  (FNUM_W),
        .PHASE_W (PHASE_W)
    ) u_inc (
        .fnum    (p_fnum),
        .block   (p_block),
        .mult    (p_mult),
        .vib     (p_vib),
        .dvb     (p_dvb),
        .vib_pos (vib_pos_q),
        .inc     (inc)
    );

    assign acc_old = acc_mem[s1_op];
    assign acc_new = (p_restart ? '0 : acc_old) + inc;

    always_comb begin
        wr_en   = s1_vld || init_wr;
        wr_addr = s1_vld ? s1_op : init_idx[OP_W-1:0];
        wr_data = s1_vld ? acc_new : '0;
    end

    // Storage has no reset; the INIT sweep clears it
    always_ff @(posedge clk) begin
        if (wr_en) begin
            acc_mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: doc/fm_phase_seq.md
Name: fm_phase_seq

Overview:
Self-sequencing phase generator for the FM synth. On each sample strobe it sweeps all NUM_OPS operators, fetches per-operator pitch parameters over a 1-cycle-latency read port, and advances each operator's phase accumulator. It streams one phase word per operator to the waveform/envelope stage. Accumulator storage is cleared by a hardware sweep after reset.

Parameters:
NUM_OPS, 64, operator count (≥2)
OP_W, $clog2(NUM_OPS), operator index width
FNUM_W, 10, F-number width (≥3)
PHASE_W, 19, accumulator width; wraps modulo 2^PHASE_W
OUT_W, 10, phase output width = accumulator MSBs (OUT_W ≤ PHASE_W)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
sample_start  in  1  one-cycle pulse: begin a sweep
vib_pos  in  3  vibrato position; captured on accepted sample_start
busy  out  1  INIT or RUN in progress
overrun  out  1  one-cycle pulse: sample_start ignored
param_addr  out  OP_W  operator whose parameters are requested
p_block  in  3  octave, valid the cycle after param_addr
p_fnum  in  FNUM_W  F-number
p_mult  in  4  MULT code
p_vib  in  1  vibrato enable
p_dvb  in  1  deep vibrato
p_restart  in  1  zero accumulator before add
phase_valid  out  1  phase_out/phase_op valid
phase_op  out  OP_W  operator index of phase_out
phase_out  out  OUT_W  pre-update accumulator[PHASE_W-1 -: OUT_W]

Behaviour:
- Reset (async assert): state=INIT, init index=0, every output=0. Release: INIT sweep writes 0 to ops 0..NUM_OPS-1, one per cycle, busy=1, no phase_valid; then IDLE. Reset asserted mid-INIT or mid-RUN aborts and restarts INIT.
- IDLE: busy=0. sample_start accepted -> RUN; vib_pos latched for the whole sweep.
- sample_start during INIT/RUN: ignored; overrun pulses the next cycle; sweep unaffected.
- Timing (sample_start high in cycle 0): cycle k+1 param_addr=k, k=0..NUM_OPS-1; cycle k+2 params for op k presented and sampled; accumulator written at the end of cycle k+2; cycle k+3 phase_valid=1, phase_op=k. busy=1 in cycles 1..NUM_OPS+1. State returns to IDLE in cycle NUM_OPS+2, and sample_start is accepted there, giving back-to-back sweeps.
- param_addr holds its last value when idle.
- Vibrato: range=fnum[FNUM_W-1 -: 3]. Range=0 if !vib or vib_pos[1:0]==0. Otherwise range>>=1 if vib_pos[0]. Then range>>=1 if !dvb. f=fnum−range if vib_pos[2], else fnum+range, mod 2^FNUM_W.
- MULT→multiplier: 0→1,1→2,2→4,3→6,4→8,5→10,6→12,7→14,8→16,9→18,10/11→20,12/13→24,14/15→30.
- inc = (((f << block) >> 1) × multiplier) >> 1, full precision, truncated to PHASE_W.
- acc_new = (restart ? 0 : acc_old) + inc, wrap modulo 2^PHASE_W.
- phase_out reports the stored value before the update, including when p_restart=1.

Decomposition:
- Package fm_pkg: MULT table function fm_mult_factor(), the state enum {INIT, IDLE, RUN}, and vibrato shift constants.
- Sub-module fm_phase_inc: pure combinational f/vibrato/multiplier/increment path, parametrised by FNUM_W and PHASE_W.
- Accumulator storage: NUM_OPS×PHASE_W array, one read and one write per cycle.

Test Plan:
- Reset release, NUM_OPS=64 -> busy=1 for exactly 64 cycles; a sample_start inside that window -> overrun pulse; the following sweep shows phase_out=0 for every op.
- fnum=0x100, block=4, mult=1, vib=0 on op 3; two sweeps -> inc=2048; second sweep phase_op=3 shows phase_out=4.
- fnum=0x380, vib=1, dvb=1: vib_pos=2 -> f=0x387; vib_pos=5 -> f=0x37D; vib_pos=5 with dvb=0 -> f=0x37F; vib_pos=0 -> f=0x380. Check via inc at block=0, mult=0.
- fnum=1023, block=7, mult=15 -> inc=457792 (wrapped from 982080); accumulator wraps modulo 2^19 across sweeps.
- p_restart=1 on op 5 mid-run -> that sweep reports the old phase, the next sweep reports inc>>9; other ops are unaffected.
- sample_start in cycle NUM_OPS+2 -> accepted with no overrun; sample_start in cycle 10 -> overrun; reset asserted mid-RUN -> outputs 0 immediately and INIT restarts.
